fsm_counter_arbiter: RTL and testbench
======================================

Name: fsm_counter_arbiter

Overview:
- Round-robin arbiter and burst sequencer that shares one fsm_counter between two requesters.
- A granted requester gets exactly its requested number of count-enable pulses on cnt_en, which drives the counter's en input.
- The block then reports completion and hands the counter to the other requester.
- Sits between requester logic and a single fsm_counter instance; the counter's own clock and reset are unchanged.

Parameters:
- LEN_W, 4, width of burst length inputs and of the internal remaining-steps counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  2  per-requester request; bit i = requester i. Must be held high until done[i].
- len0  input  LEN_W  burst length for requester 0; sampled only in GRANT.
- len1  input  LEN_W  burst length for requester 1; sampled only in GRANT.
- gnt  output  2  one-hot grant (or 0), registered.
- cnt_en  output  1  enable to shared counter, registered.
- done  output  2  one-cycle completion pulse per requester, registered.
- busy  output  1  high whenever state is not IDLE.
- steps_left  output  LEN_W  remaining cnt_en pulses in current burst.

Behaviour:
- Reset (async, any state): state=IDLE, gnt=0, cnt_en=0, done=0, busy=0, steps_left=0, last-served pointer=1, so requester 0 wins the first arbitration.
- States: IDLE, GRANT, RUN, DONE.
- IDLE, req==0: stay; all outputs 0.
- IDLE, req!=0: winner = sole requester; if both request, the one not equal to last-served. Next cycle: GRANT, gnt one-hot to winner, last-served <= winner.
- GRANT (exactly 1 cycle): latch len of the granted requester into steps_left.
  - latched len == 0: next state DONE; no cnt_en pulse.
  - latched len != 0: next state RUN.
- RUN: cnt_en=1 every cycle. steps_left decrements by 1 per cycle, reaching 0 in the cycle cnt_en drops.
  - cnt_en high for exactly L consecutive cycles, L = latched length, range 1..2^LEN_W-1.
  - After the L-th pulse: state DONE.
- DONE (1 cycle): done[winner]=1, gnt still asserted, cnt_en=0. Next state IDLE, gnt=0.
- Latency: from first cycle req seen high in IDLE, gnt rises 1 cycle later and cnt_en 2 cycles later. done rises the cycle after the last cnt_en.
- Return to IDLE always takes one cycle: back-to-back bursts are separated by one IDLE cycle and one GRANT cycle with cnt_en=0.
- Requester holding req through done is re-arbitrated normally. If the other requester is also waiting, the other wins (fairness).
- Abort: granted req bit falls during GRANT or RUN.
  - Next cycle: state IDLE, cnt_en=0, gnt=0, steps_left=0, no done pulse.
  - Last-served keeps the aborted requester.
- Length inputs changing after GRANT: ignored.
- Non-granted req changes while busy: ignored until IDLE.
- Length wrap: steps_left never underflows; decrement is gated at 0.
- gnt and done are never asserted for both bits at once.

Test Plan:
- Reset mid-RUN: req=01, len0=5, assert reset in the 3rd RUN cycle -> all outputs 0 immediately (asynchronous). After release, req=11 -> requester 0 granted first.
- Single burst: req=01, len0=3 -> gnt=01 at T+1; cnt_en high T+2..T+4; done=01 at T+5 only; gnt=00 at T+6. Counter num advances by exactly 3.
- Contention fairness: req=11 held, len0=2, len1=4 -> grant order 0,1,0,1 with 2,4,2,4 cnt_en pulses; never two consecutive grants to the same requester.
- Zero length: req=10, len1=0 -> GRANT then DONE, cnt_en never high, done=10 one cycle.
- Abort: req=01, len0=7, drop req[0] after 3 cnt_en pulses -> cnt_en low next cycle, no done, busy=0. A following req=11 grants requester 1.
- Max length: len0=15 -> exactly 15 cnt_en cycles; steps_left counts 15 down to 0; num wraps 7->0 twice without glitches.

Source files
------------

// File: rtl/fsm_counter_arbiter_if.sv
// Requester-side bus of the shared-counter arbiter: requests and burst
// lengths in, grant/enable/completion status out.
interface fsm_counter_arbiter_if #(
    parameter int LEN_W = 4
);
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       gnt;
    logic             cnt_en;
    logic [1:0]       done;
    logic             busy;
    logic [LEN_W-1:0] steps_left;

    modport master (
        output req, len0, len1,
        input  gnt, cnt_en, done, busy, steps_left
    );

    modport slave (
        input  req, len0, len1,
        output gnt, cnt_en, done, busy, steps_left
    );
endinterface

// File: rtl/fsm_counter_arbiter.sv
// Round-robin arbiter that lends one shared counter to two requesters,
// issuing exactly the requested number of cnt_en pulses per burst.
module fsm_counter_arbiter #(
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fsm_counter_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       gnt_q, gnt_nxt;
    logic             cnt_en_q, cnt_en_nxt;
    logic [1:0]       done_q, done_nxt;
    logic [LEN_W-1:0] steps_q, steps_nxt;
    logic             last_q, last_nxt;

    logic             winner;
    logic             granted_req;
    logic [LEN_W-1:0] granted_len;

    // On contention the requester that was not served last wins.
    always_comb begin
        winner = 1'b0;
        case (bus.req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_q;
            default: winner = 1'b0;
        endcase
    end

    assign granted_req = |(bus.req & gnt_q);
    assign granted_len = gnt_q[1] ? bus.len1 : bus.len0;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_nxt  = state;
        gnt_nxt    = gnt_q;
        cnt_en_nxt = 1'b0;
        done_nxt   = 2'b00;
        steps_nxt  = steps_q;
        last_nxt   = last_q;

        unique case (state)
            IDLE: begin
                gnt_nxt   = 2'b00;
                steps_nxt = '0;
                if (bus.req != 2'b00) begin
                    state_nxt = GRANT;
                    gnt_nxt   = winner ? 2'b10 : 2'b01;
                    last_nxt  = winner;
                end
            end

            GRANT: begin
                if (!granted_req) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 2'b00;
                    steps_nxt = '0;
                end else begin
                    steps_nxt = granted_len;
                    if (granted_len == '0) begin
                        state_nxt = DONE;
                        done_nxt  = gnt_q;
                    end else begin
                        state_nxt  = RUN;
                        cnt_en_nxt = 1'b1;
                    end
                end
            end

            RUN: begin
                if (!granted_req) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 2'b00;
                    steps_nxt = '0;
                end else begin
                    // Gated decrement: steps_left can never wrap below zero.
                    if (steps_q != '0) begin
                        steps_nxt = steps_q - LEN_W'(1);
                    end
                    if (steps_q <= LEN_W'(1)) begin
                        state_nxt = DONE;
                        done_nxt  = gnt_q;
                    end else begin
                        cnt_en_nxt = 1'b1;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
                gnt_nxt   = 2'b00;
                steps_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt_q    <= 2'b00;
            cnt_en_q <= 1'b0;
            done_q   <= 2'b00;
            steps_q  <= '0;
            last_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state    <= state_nxt;
            gnt_q    <= gnt_nxt;
            cnt_en_q <= cnt_en_nxt;
            done_q   <= done_nxt;
            steps_q  <= steps_nxt;
            last_q   <= last_nxt;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.cnt_en     = cnt_en_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state != IDLE);
    assign bus.steps_left = steps_q;

endmodule

// File: tb/tb_fsm_counter_arbiter.sv
// Self-checking bench for fsm_counter_arbiter: directed scenarios plus random
// bursts, compared against a timeline model derived from the burst rules.
module tb_fsm_counter_arbiter;

    localparam int LEN_W = 4;

    logic clk;
    logic reset;

    fsm_counter_arbiter_if #(.LEN_W(LEN_W)) bus ();

    fsm_counter_arbiter #(.LEN_W(LEN_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0] gnt;
        logic       en;
        logic [1:0] done;
        logic       busy;
        logic [3:0] sl;
    } obs_t;

    int checks     = 0;
    int failures   = 0;
    int model_last = 1;

    function automatic obs_t sample();
        obs_t o;
        o.gnt  = bus.gnt;
        o.en   = bus.cnt_en;
        o.done = bus.done;
        o.busy = bus.busy;
        o.sl   = bus.steps_left;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("gnt=%b en=%b done=%b busy=%b steps_left=%0d",
                         o.gnt, o.en, o.done, o.busy, o.sl);
    endfunction

    // Expected outputs k cycles after a request is first seen in IDLE by a
    // burst of length len granted to requester w (k=0 is that IDLE cycle).
    function automatic obs_t expect_at(int k, int len, int w);
        obs_t e;
        e = '0;
        if (k >= 1 && k <= len + 2) begin
            e.gnt  = (w == 1) ? 2'b10 : 2'b01;
            e.busy = 1'b1;
        end
        if (k >= 2 && k <= len + 1) begin
            e.en = 1'b1;
            e.sl = 4'(len + 2 - k);
        end
        if (k == len + 2) e.done = e.gnt;
        return e;
    endfunction

    function automatic int pick(logic [1:0] r, int last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return (last == 0) ? 1 : 0;
    endfunction

    task automatic test_reset();
        obs_t got;
        reset    = 1'b1;
        bus.req  = 2'b00;
        bus.len0 = '0;
        bus.len1 = '0;
        repeat (2) @(negedge clk);
        got = sample();
        checks++;
        if (got !== obs_t'(0)) begin
            failures++;
            $display("FAIL reset_state got %s required all zero", fmt(got));
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        got = sample();
        checks++;
        if (got !== obs_t'(0)) begin
            failures++;
            $display("FAIL idle_no_req got %s required all zero", fmt(got));
        end
        model_last = 1;
    endtask

    task automatic test_reset_mid_run();
        obs_t got, exp;
        int   w;
        bus.len0 = 4'd5;
        bus.req  = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            got = sample();
            exp = expect_at(k, 5, 0);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL mid_run k=%0d got %s required %s", k, fmt(got), fmt(exp));
            end
        end
        // Third RUN cycle: assert reset away from any clock edge.
        #1 reset = 1'b1;
        #1 got = sample();
        checks++;
        if (got !== obs_t'(0)) begin
            failures++;
            $display("FAIL async_reset got %s required all zero", fmt(got));
        end
        @(negedge clk);
        reset      = 1'b0;
        model_last = 1;
        bus.req    = 2'b11;
        bus.len0   = 4'd1;
        bus.len1   = 4'd1;
        w = pick(2'b11, model_last);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            got = sample();
            exp = expect_at(k, 1, w);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL post_reset_grant k=%0d got %s required %s", k, fmt(got), fmt(exp));
            end
            if (k == 3) bus.req = 2'b00;
        end
        model_last = w;
    endtask

    task automatic run_directed(input string name, input logic [1:0] r,
                                input int l0, input int l1);
        obs_t got, exp;
        int   w, len, pulses;
        w        = pick(r, model_last);
        len      = (w == 1) ? l1 : l0;
        pulses   = 0;
        bus.len0 = 4'(l0);
        bus.len1 = 4'(l1);
        bus.req  = r;
        for (int k = 1; k <= len + 3; k++) begin
            @(negedge clk);
            got = sample();
            exp = expect_at(k, len, w);
            if (got.en === 1'b1) pulses++;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s k=%0d got %s required %s", name, k, fmt(got), fmt(exp));
            end
            if (k == len + 2) bus.req = 2'b00;
        end
        checks++;
        if (pulses != len) begin
            failures++;
            $display("FAIL %s_pulses got %0d required %0d", name, pulses, len);
        end
        model_last = w;
    endtask

    task automatic test_single_burst();
        run_directed("single_burst", 2'b01, 3, 9);
    endtask

    task automatic test_zero_length();
        run_directed("zero_length", 2'b10, 6, 0);
    endtask

    task automatic test_max_length();
        run_directed("max_length", 2'b01, 15, 2);
    endtask

    task automatic test_abort();
        obs_t got, exp;
        int   w;
        bus.len0 = 4'd7;
        bus.len1 = 4'd3;
        bus.req  = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            got = sample();
            exp = (k <= 4) ? expect_at(k, 7, 0) : obs_t'(0);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL abort k=%0d got %s required %s", k, fmt(got), fmt(exp));
            end
            if (k == 4) bus.req = 2'b00;
        end
        model_last = 0;
        bus.len1 = 4'd2;
        bus.req  = 2'b11;
        w = pick(2'b11, model_last);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            got = sample();
            exp = expect_at(k, 2, w);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL after_abort k=%0d got %s required %s", k, fmt(got), fmt(exp));
            end
            if (k == 4) bus.req = 2'b00;
        end
        model_last = w;
    endtask

    task automatic test_back_to_back();
        obs_t       got, exp;
        logic [1:0] prev_gnt;
        int         w, len;
        bus.len0 = 4'd2;
        bus.len1 = 4'd4;
        bus.req  = 2'b11;
        prev_gnt = 2'b00;
        w = pick(2'b11, model_last);
        for (int b = 0; b < 4; b++) begin
            len = (w == 1) ? 4 : 2;
            for (int k = 1; k <= len + 3; k++) begin
                @(negedge clk);
                got = sample();
                exp = expect_at(k, len, w);
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL back_to_back b=%0d k=%0d got %s required %s",
                             b, k, fmt(got), fmt(exp));
                end
                if (k == 1) begin
                    checks++;
                    if (got.gnt === prev_gnt) begin
                        failures++;
                        $display("FAIL fairness b=%0d got gnt=%b required different from previous %b",
                                 b, got.gnt, prev_gnt);
                    end
                    prev_gnt = got.gnt;
                end
                if (b == 3 && k == len + 2) bus.req = 2'b00;
            end
            model_last = w;
            w = pick(2'b11, model_last);
        end
    endtask

    task automatic test_random();
        obs_t       got, exp;
        logic [1:0] r;
        int         w, len, l0, l1;
        for (int it = 0; it < 40; it++) begin
            r   = 2'($urandom_range(1, 3));
            l0  = $urandom_range(0, 15);
            l1  = $urandom_range(0, 15);
            w   = pick(r, model_last);
            len = (w == 1) ? l1 : l0;
            bus.len0 = 4'(l0);
            bus.len1 = 4'(l1);
            bus.req  = r;
            for (int k = 1; k <= len + 3; k++) begin
                @(negedge clk);
                got = sample();
                exp = expect_at(k, len, w);
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL random it=%0d k=%0d got %s required %s",
                             it, k, fmt(got), fmt(exp));
                end
                if (k == len + 2) begin
                    bus.req = 2'b00;
                end else if (k < len + 2) begin
                    // Disturb everything the arbiter must ignore while busy.
                    bus.req = (w == 1) ? {1'b1, 1'($urandom_range(0, 1))}
                                       : {1'($urandom_range(0, 1)), 1'b1};
                    if (k >= 2) begin
                        bus.len0 = 4'($urandom_range(0, 15));
                        bus.len1 = 4'($urandom_range(0, 15));
                    end
                end
            end
            model_last = w;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_single_burst();
        test_back_to_back();
        test_zero_length();
        test_abort();
        test_max_length();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
